// File: rtl/arb_rr_4_1.sv
// arb_rr_4_1: 4-channel round-robin arbiter with a registered output slot.
// Ports: clk, rst (async, active-high), in_valid[3:0], in_data0..3,
//   in_ready[3:0] (comb), out_valid, out_ready, out_data, out_sel[1:0].
// Build option: define ARB_RR_4_1_ROUND_ROBIN_EN for rotating priority;
//   otherwise fixed priority with index 0 highest.
module arb_rr_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic [WIDTH-1:0] data [4];
  logic [1:0]       ptr;
  logic [1:0]       g;
  logic [1:0]       idx;
  logic             any;
  logic             can_load;
  logic             accept;

  assign data[0] = in_data0;
  assign data[1] = in_data1;
  assign data[2] = in_data2;
  assign data[3] = in_data3;

  assign any      = |in_valid;
  assign can_load = !out_valid || out_ready;
  assign accept   = !rst && can_load && any;

  // Scan from ptr upward; walking k downward
  // lets the nearest valid index win.
  always_comb begin
    g   = '0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (in_valid[idx]) g = idx;
    end
  end

  // rst gates in_ready so nothing is offered
  // while the slot is forced empty.
  assign in_ready = accept ? (4'b0001 << g) : 4'b0000;

`ifdef ARB_RR_4_1_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= g + 2'd1;
    end
  end
`else
  assign ptr = 2'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data[g];
      out_sel   <= g;
    end else if (out_ready) begin
      // Drain: data/sel keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_rr_4_1.sv
// tb_arb_rr_4_1: directed plus random checks of arb_rr_4_1
// against a behavioural reference model.
module tb_arb_rr_4_1;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int pass_cnt = 0;
  int chk_cnt  = 0;

`ifdef ARB_RR_4_1_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // reference model state
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;

  always #5 clk = ~clk;

  arb_rr_4_1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic check(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
    chk_cnt++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s: got %h want %h", tag, o, e);
  endtask

  function automatic int gnt(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input int i);
    case (i)
      0:       return in_data0;
      1:       return in_data1;
      2:       return in_data2;
      default: return in_data3;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
  endtask

  task automatic check_out(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".sel"},   32'(out_sel),   32'(m_sel));
    check({tag, ".data"},  32'(out_data),  32'(m_data));
  endtask

  // one cycle: drive at negedge, check in_ready,
  // clock, update model, check slot
  task automatic step(input string tag,
                      input logic [3:0] v,
                      input logic [WIDTH-1:0] d0,
                      input logic [WIDTH-1:0] d1,
                      input logic [WIDTH-1:0] d2,
                      input logic [WIDTH-1:0] d3,
                      input logic ordy);
    int   g;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_data0  = d0;
    in_data1  = d1;
    in_data2  = d2;
    in_data3  = d3;
    out_ready = ordy;
    #1;
    g   = gnt(v, RR ? m_ptr : 0);
    acc = (!m_valid || ordy) && (g >= 0);
    check({tag, ".rdy"}, 32'(in_ready),
          acc ? 32'(1 << g) : 32'd0);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_data  = pick(g);
      m_sel   = g;
      if (RR) m_ptr = (g + 1) % 4;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_out(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data0  = '0;
    in_data1  = '0;
    in_data2  = '0;
    in_data3  = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_out("rst0");
    check("rst0.rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single request
    step("single", 4'b0100, 4'h0, 4'h0, 4'hc, 4'h0, 1'b1);
    check("single.sel2", 32'(out_sel), 32'd2);
    check("single.datc", 32'(out_data), 32'hc);

    // rotation (or fixed priority)
    model_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("rot", 4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
      check("rot.sel", 32'(out_sel), RR ? 32'(i % 4) : 32'd0);
    end

    // wrap: grant 3, then 1001 twice
    step("wrap3", 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    step("wrapa", 4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("wrapa.sel", 32'(out_sel), 32'd0);
    step("wrapb", 4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    check("wrapb.sel", 32'(out_sel), RR ? 32'd3 : 32'd0);

    // backpressure
    step("bp.ld", 4'b0010, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("bp.hold", 4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b0);
      check("bp.hsel", 32'(out_sel), 32'd1);
      check("bp.hdat", 32'(out_data), 32'hb);
    end
    step("bp.rel", 4'b1111, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
    check("bp.rsel", 32'(out_sel), RR ? 32'd2 : 32'd0);

    // X passthrough then drain
    step("xp", 4'b1000, 4'h0, 4'h0, 4'h0, 'x, 1'b1);
    check("xp.dat", 32'(out_data), 32'(4'bxxxx));
    step("xp.drn", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    check("xp.val", 32'(out_valid), 32'd0);

    // async reset mid-hold
    step("ar.ld", 4'b0010, 4'h0, 4'hb, 4'h0, 4'h0, 1'b1);
    step("ar.hld", 4'b1111, 4'h0, 4'hb, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_out("arst");
    check("arst.rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_out("arst.edge");
    check("arst.erdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step("rnd",
           4'($urandom),
           4'($urandom), 4'($urandom),
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
